// File: rtl/l1_cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped L1 data cache.
// Purely declarative: no logic, no latency, no flow control.
package l1_cache_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPARE    = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } state_t;

  localparam int L1_DATA_WIDTH = 32;
  localparam int L1_BLOCK_SIZE = 16;

  typedef logic [L1_BLOCK_SIZE-1:0][L1_DATA_WIDTH-1:0] block_t;

  function automatic int offset_w(input int block_size);
    return $clog2(block_size);
  endfunction

  function automatic int index_w(input int cache_size, input int block_size);
    return $clog2(cache_size / block_size);
  endfunction

  function automatic int tag_w(input int addr_width, input int cache_size, input int block_size);
    return addr_width - index_w(cache_size, block_size) - offset_w(block_size);
  endfunction

endpackage

// File: rtl/l1_line_store.sv
// Tag/valid/dirty/data arrays: combinational read by index, registered write next edge.
// Never stalls; the caller issues at most one of fill, word merge or clean per cycle.
module l1_line_store
  import l1_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_LINES  = 16,
  parameter int INDEX_W    = 4,
  parameter int OFFSET_W   = 4,
  parameter int TAG_W      = 24
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [INDEX_W-1:0]                    index,
  output logic                                  rd_valid,
  output logic                                  rd_dirty,
  output logic [TAG_W-1:0]                      rd_tag,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rd_line,
  input  logic                                  fill_en,
  input  logic [TAG_W-1:0]                      fill_tag,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] fill_line,
  input  logic                                  word_en,
  input  logic [OFFSET_W-1:0]                   word_off,
  input  logic [DATA_WIDTH-1:0]                 word_data,
  input  logic                                  clean_en
);

  logic [NUM_LINES-1:0]                  valid_q;
  logic [NUM_LINES-1:0]                  dirty_q;
  logic [TAG_W-1:0]                      tag_q  [NUM_LINES];
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] data_q [NUM_LINES];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_line  = data_q[index];

  // Only the state bits are reset; tag/data contents are meaningless while invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_en) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end
      if (word_en)  dirty_q[index] <= 1'b1;
      if (clean_en) dirty_q[index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[index]  <= fill_tag;
      data_q[index] <= fill_line;
    end
    if (word_en) data_q[index][word_off] <= word_data;
  end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back/write-allocate L1: hit answers 2 cycles after accept, miss adds L2 time + 1.
// CPU holds its request until the cpu_ready pulse; L2 requests stay high until l2_ready is sampled.
module l1_dcache
  import l1_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_SIZE = 256,
  parameter int BLOCK_SIZE = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [DATA_WIDTH-1:0]            cpu_data_in,
  input  logic                             cpu_read,
  input  logic                             cpu_write,
  output logic [DATA_WIDTH-1:0]            cpu_data_out,
  output logic                             cpu_ready,
  output logic                             cpu_hit,
  output logic [ADDR_WIDTH-1:0]            l2_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_out,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_in,
  output logic                             l2_read,
  output logic                             l2_write,
  input  logic                             l2_ready
);

  localparam int NUM_LINES = CACHE_SIZE / BLOCK_SIZE;
  localparam int OFFSET_W  = offset_w(BLOCK_SIZE);
  localparam int INDEX_W   = index_w(CACHE_SIZE, BLOCK_SIZE);
  localparam int TAG_W     = tag_w(ADDR_WIDTH, CACHE_SIZE, BLOCK_SIZE);

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_write;
  logic                  replay;

  logic [OFFSET_W-1:0] req_offset;
  logic [INDEX_W-1:0]  req_index;
  logic [TAG_W-1:0]    req_tag;

  logic                                  rd_valid, rd_dirty;
  logic [TAG_W-1:0]                      rd_tag;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rd_line;

  logic accept, hit, hit_resp, fill_en, word_en, clean_en;

  assign req_offset = req_addr[OFFSET_W-1:0];
  assign req_index  = req_addr[OFFSET_W +: INDEX_W];
  assign req_tag    = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign hit        = rd_valid && (rd_tag == req_tag);

  l1_line_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE),
    .NUM_LINES  (NUM_LINES),
    .INDEX_W    (INDEX_W),
    .OFFSET_W   (OFFSET_W),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .index     (req_index),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .fill_en   (fill_en),
    .fill_tag  (req_tag),
    .fill_line (l2_data_in),
    .word_en   (word_en),
    .word_off  (req_offset),
    .word_data (req_wdata),
    .clean_en  (clean_en)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    hit_resp   = 1'b0;
    fill_en    = 1'b0;
    word_en    = 1'b0;
    clean_en   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_read || cpu_write) begin
          accept     = 1'b1;
          state_next = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          hit_resp   = 1'b1;
          word_en    = req_write;
          state_next = IDLE;
        end else if (rd_valid && rd_dirty) begin
          state_next = WRITE_BACK;
        end else begin
          state_next = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        if (l2_ready) begin
          clean_en   = 1'b1;
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (l2_ready) begin
          fill_en    = 1'b1;
          state_next = COMPARE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // L2 side is a pure function of the registered state, so it drops the edge after reset.
  assign l2_read     = (state == ALLOCATE);
  assign l2_write    = (state == WRITE_BACK);
  assign l2_data_out = (state == WRITE_BACK) ? rd_line : '0;

  always_comb begin
    l2_addr = '0;
    if (state == WRITE_BACK)    l2_addr = {rd_tag,  req_index, {OFFSET_W{1'b0}}};
    else if (state == ALLOCATE) l2_addr = {req_tag, req_index, {OFFSET_W{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_addr     <= '0;
      req_wdata    <= '0;
      req_write    <= 1'b0;
      replay       <= 1'b0;
      cpu_ready    <= 1'b0;
      cpu_hit      <= 1'b0;
      cpu_data_out <= '0;
    end else begin
      cpu_ready    <= hit_resp;
      cpu_hit      <= hit_resp && !replay;
      cpu_data_out <= (hit_resp && !req_write) ? rd_line[req_offset] : '0;
      if (accept) begin
        req_addr  <= cpu_addr;
        req_wdata <= cpu_data_in;
        req_write <= cpu_write;
        replay    <= 1'b0;
      end
      if (fill_en) replay <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache: linear request sequence with an inline L2 responder.
module tb_l1_dcache;
  import l1_cache_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  cpu_addr, cpu_data_in, cpu_data_out;
  logic         cpu_read, cpu_write, cpu_ready, cpu_hit;
  logic [31:0]  l2_addr;
  logic [511:0] l2_data_out, l2_data_in;
  logic         l2_read, l2_write, l2_ready;

  int checks   = 0;
  int failures = 0;

  block_t blk_a, blk_b, blk_c, seen;

  l1_dcache dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_addr     (cpu_addr),
    .cpu_data_in  (cpu_data_in),
    .cpu_read     (cpu_read),
    .cpu_write    (cpu_write),
    .cpu_data_out (cpu_data_out),
    .cpu_ready    (cpu_ready),
    .cpu_hit      (cpu_hit),
    .l2_addr      (l2_addr),
    .l2_data_out  (l2_data_out),
    .l2_data_in   (l2_data_in),
    .l2_read      (l2_read),
    .l2_write     (l2_write),
    .l2_ready     (l2_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_req(input logic [31:0] a, input logic [31:0] d, input bit rd, input bit wr);
    @(negedge clk);
    cpu_addr    = a;
    cpu_data_in = d;
    cpu_read    = rd;
    cpu_write   = wr;
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  // Expect cpu_ready on the first edge sampled, with no L2 request seen meanwhile.
  task automatic wait_ready(input string tag, input logic [31:0] exp_data, input bit exp_hit);
    int  n = 0;
    bit  l2_seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (l2_read || l2_write) l2_seen = 1'b1;
      if (cpu_ready) begin
        n = i;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(n), 64'd1);
    chk({tag, "_no_l2"}, 64'(l2_seen), 64'd0);
    chk({tag, "_data"}, 64'(cpu_data_out), 64'(exp_data));
    chk({tag, "_hit"}, 64'(cpu_hit), 64'(exp_hit));
  endtask

  // Waits for one L2 request, checks it, holds it 3 cycles, then answers with fill.
  task automatic l2_serve(input string tag, input bit exp_wr, input logic [31:0] exp_addr,
                          input block_t fill, output block_t got);
    bit req_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (l2_read || l2_write) begin
        req_seen = 1'b1;
        break;
      end
    end
    chk({tag, "_req_seen"}, 64'(req_seen), 64'd1);
    chk({tag, "_l2_write"}, 64'(l2_write), 64'(exp_wr));
    chk({tag, "_l2_read"}, 64'(l2_read), 64'(!exp_wr));
    chk({tag, "_l2_addr"}, 64'(l2_addr), 64'(exp_addr));
    got = l2_data_out;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_req"}, 64'(exp_wr ? l2_write : l2_read), 64'd1);
      chk({tag, "_hold_addr"}, 64'(l2_addr), 64'(exp_addr));
    end
    @(negedge clk);
    l2_ready   = 1'b1;
    l2_data_in = fill;
    @(posedge clk);
    #1;
    l2_ready = 1'b0;
    chk({tag, "_req_drop"}, 64'(exp_wr ? l2_write : l2_read), 64'd0);
    chk({tag, "_not_both"}, 64'(l2_read && l2_write), 64'd0);
  endtask

  initial begin
    bit req_seen;
    for (int i = 0; i < 16; i++) begin
      blk_a[i] = 32'hA000_0000 + 32'(i);
      blk_b[i] = 32'hB000_0000 + 32'(i);
      blk_c[i] = 32'hC000_0000 + 32'(i);
    end
    rst_n = 1'b0;
    cpu_addr = '0; cpu_data_in = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    l2_data_in = '0; l2_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_ready", 64'(cpu_ready), 64'd0);
    chk("rst_cpu_hit", 64'(cpu_hit), 64'd0);
    chk("rst_cpu_data", 64'(cpu_data_out), 64'd0);
    chk("rst_l2_rw", 64'({l2_read, l2_write}), 64'd0);
    chk("rst_l2_addr", 64'(l2_addr), 64'd0);
    chk("rst_l2_data", 64'(l2_data_out[63:0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold read miss, then the pulse must end the following cycle.
    cpu_req(32'h123, 32'h0, 1'b1, 1'b0);
    l2_serve("cold_fill", 1'b0, 32'h120, blk_a, seen);
    wait_ready("cold_rd", 32'hA000_0003, 1'b0);
    @(posedge clk);
    #1;
    chk("cold_ready_pulse", 64'(cpu_ready), 64'd0);
    chk("cold_data_clear", 64'(cpu_data_out), 64'd0);

    cpu_req(32'h12F, 32'h0, 1'b1, 1'b0);
    wait_ready("hit_last_word", 32'hA000_000F, 1'b1);

    // Store hit dirties index 2; conflicting read forces write-back then fill.
    cpu_req(32'h123, 32'hDEAD_BEEF, 1'b0, 1'b1);
    wait_ready("wr_hit", 32'h0, 1'b1);
    cpu_req(32'h223, 32'h0, 1'b1, 1'b0);
    l2_serve("wb_120", 1'b1, 32'h120, blk_a, seen);
    chk("wb_120_word3", 64'(seen[3]), 64'hDEAD_BEEF);
    chk("wb_120_word0", 64'(seen[0]), 64'hA000_0000);
    l2_serve("fill_220", 1'b0, 32'h220, blk_b, seen);
    wait_ready("rd_223", 32'hB000_0003, 1'b0);

    // Write miss allocates then merges on replay.
    cpu_req(32'h345, 32'h1234_5678, 1'b0, 1'b1);
    l2_serve("fill_340", 1'b0, 32'h340, blk_c, seen);
    wait_ready("wr_miss", 32'h0, 1'b0);
    cpu_req(32'h345, 32'h0, 1'b1, 1'b0);
    wait_ready("rd_345", 32'h1234_5678, 1'b1);
    cpu_req(32'h745, 32'h0, 1'b1, 1'b0);
    l2_serve("wb_340", 1'b1, 32'h340, blk_a, seen);
    chk("wb_340_word5", 64'(seen[5]), 64'h1234_5678);
    chk("wb_340_word4", 64'(seen[4]), 64'hC000_0004);
    l2_serve("fill_740", 1'b0, 32'h740, blk_a, seen);
    wait_ready("rd_745", 32'hA000_0005, 1'b0);

    // Last line, last word, and a clean conflict on it.
    cpu_req(32'h0FF, 32'h0, 1'b1, 1'b0);
    l2_serve("fill_0f0", 1'b0, 32'h0F0, blk_b, seen);
    wait_ready("rd_0ff", 32'hB000_000F, 1'b0);
    cpu_req(32'h1FF, 32'h0, 1'b1, 1'b0);
    l2_serve("fill_1f0", 1'b0, 32'h1F0, blk_c, seen);
    wait_ready("rd_1ff", 32'hC000_000F, 1'b0);

    // Dirty index 4, then reset while a fill of index 2 is outstanding.
    cpu_req(32'h745, 32'h0000_0077, 1'b0, 1'b1);
    wait_ready("wr_745", 32'h0, 1'b1);
    cpu_req(32'h523, 32'h0, 1'b1, 1'b0);
    req_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (l2_read) begin
        req_seen = 1'b1;
        break;
      end
    end
    chk("alloc_520_seen", 64'(req_seen), 64'd1);
    chk("alloc_520_addr", 64'(l2_addr), 64'h520);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_l2_read", 64'(l2_read), 64'd0);
    chk("midrst_l2_write", 64'(l2_write), 64'd0);
    chk("midrst_l2_addr", 64'(l2_addr), 64'd0);
    chk("midrst_cpu_ready", 64'(cpu_ready), 64'd0);
    chk("midrst_cpu_data", 64'(cpu_data_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cpu_req(32'h123, 32'h0, 1'b1, 1'b0);
    l2_serve("refill_120", 1'b0, 32'h120, blk_a, seen);
    wait_ready("rerd_123", 32'hA000_0003, 1'b0);
    cpu_req(32'h745, 32'h0, 1'b1, 1'b0);
    l2_serve("refill_740", 1'b0, 32'h740, blk_b, seen);
    wait_ready("rerd_745", 32'hB000_0005, 1'b0);

    // Stray l2_ready in IDLE must do nothing.
    @(negedge clk);
    l2_ready = 1'b1;
    @(posedge clk);
    #1;
    l2_ready = 1'b0;
    chk("stray_cpu_ready", 64'(cpu_ready), 64'd0);
    chk("stray_l2_rw", 64'({l2_read, l2_write}), 64'd0);
    @(posedge clk);
    #1;
    chk("stray_cpu_ready2", 64'(cpu_ready), 64'd0);
    chk("stray_l2_rw2", 64'({l2_read, l2_write}), 64'd0);

    // Read and write together behave as a write.
    cpu_req(32'h12A, 32'hCAFE_F00D, 1'b1, 1'b1);
    wait_ready("dual_req", 32'h0, 1'b1);
    cpu_req(32'h22A, 32'h0, 1'b1, 1'b0);
    l2_serve("wb_dual", 1'b1, 32'h120, blk_a, seen);
    chk("wb_dual_word10", 64'(seen[10]), 64'hCAFE_F00D);
    chk("wb_dual_word3", 64'(seen[3]), 64'hA000_0003);
    l2_serve("fill_dual", 1'b0, 32'h220, blk_b, seen);
    wait_ready("rd_22a", 32'hB000_000A, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l1_dcache.md
Name: l1_dcache

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the CPU load/store port and L2_cache.
- CPU side is word-granular: one word per request.
- L2 side moves whole blocks using the L2 block-request handshake: read or write held high until ready.
- Addresses are word addresses, matching the L2 addressing.

Parameters:
- DATA_WIDTH, 32, bits per word.
- ADDR_WIDTH, 32, word-address width.
- CACHE_SIZE, 256, total capacity in words; must be a power of two.
- BLOCK_SIZE, 16, words per line; must equal the L1_BLOCK_SIZE seen by L2.
- Derived: NUM_LINES=CACHE_SIZE/BLOCK_SIZE; OFFSET_W=clog2(BLOCK_SIZE); INDEX_W=clog2(NUM_LINES); TAG_W=ADDR_WIDTH-INDEX_W-OFFSET_W.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cpu_addr  in  ADDR_WIDTH  word address
cpu_data_in  in  DATA_WIDTH  store data
cpu_read  in  1  load request
cpu_write  in  1  store request
cpu_data_out  out  DATA_WIDTH  load data, valid with cpu_ready
cpu_ready  out  1  one-cycle completion pulse
cpu_hit  out  1  with cpu_ready: request hit without an L2 access
l2_addr  out  ADDR_WIDTH  block-aligned address {tag,index,OFFSET_W'0}
l2_data_out  out  BLOCK_SIZE*DATA_WIDTH  victim block; word i at bits [i*DATA_WIDTH+:DATA_WIDTH]
l2_data_in  in  BLOCK_SIZE*DATA_WIDTH  fill block, same packing
l2_read  out  1  fill request
l2_write  out  1  write-back request
l2_ready  in  1  L2 completion

Behaviour:
- Reset: every output is 0. All valid and dirty bits clear. FSM goes to IDLE. Reset mid-operation aborts the access: any L2 request drops on the next edge and dirty data is discarded.
- FSM states: IDLE, COMPARE, WRITE_BACK, ALLOCATE.
- IDLE, accepting a request:
  - A request is accepted on any edge with cpu_read|cpu_write high.
  - addr, wdata and op are latched into request registers. CPU inputs are ignored until cpu_ready.
  - cpu_read and cpu_write both high: treated as a write.
  - Next state is COMPARE.
- COMPARE, hit (valid && tag match):
  - Registered cpu_ready=1 for one cycle.
  - Read: cpu_data_out=line word[offset].
  - Write: that word is updated and dirty set; cpu_data_out=0.
  - cpu_hit=1 unless the request was replayed after a fill.
  - Next state is IDLE.
  - Hit latency: cpu_ready is high in the second cycle after the accepting edge.
- COMPARE, miss:
  - dirty victim: go to WRITE_BACK.
  - otherwise: go to ALLOCATE.
- WRITE_BACK:
  - l2_write=1, l2_addr={victim_tag,index,0}, l2_data_out=victim line.
  - All three are held stable until l2_ready is sampled high.
  - Then: l2_write=0, dirty cleared, go to ALLOCATE.
- ALLOCATE:
  - l2_read=1, l2_addr={req_tag,index,0}, held until l2_ready.
  - On l2_ready: line is loaded from l2_data_in; valid=1, tag=req_tag, dirty=0; l2_read=0; go to COMPARE.
  - The replay in COMPARE then hits, and a store merges then (cpu_hit=0).
- Miss latency: 2 + (L2 cycles) + 1 replay cycle.
- l2_read and l2_write are never high together. l2_ready is ignored unless one of them is high.
- cpu_ready and cpu_hit are pulses. cpu_data_out returns to 0 in the cycle after cpu_ready.
- Offset select: offset=req_addr[OFFSET_W-1:0]. No byte enables.
- Every index wraps naturally. Last line (index NUM_LINES-1) and word BLOCK_SIZE-1 must behave like any other.

Decomposition:
- Package l1_cache_pkg holds:
  - the state enum (2 bits: IDLE, COMPARE, WRITE_BACK, ALLOCATE);
  - localparam functions for OFFSET_W/INDEX_W/TAG_W;
  - a block_t typedef [BLOCK_SIZE-1:0][DATA_WIDTH-1:0].
- Sub-module l1_line_store:
  - holds tag/valid/dirty/data arrays;
  - one combinational read port by index;
  - one registered write port with full-line fill, single-word merge, dirty set/clear, and clear-all on reset.
- Top: FSM, request registers, L2 handshake.

Test Plan:
- Cold read 0x0000_0123 -> l2_read=1 with l2_addr=0x120. Return block word[i]=0xA000_0000+i, ready after 3 cycles -> cpu_ready pulse, cpu_data_out=0xA000_0003, cpu_hit=0.
- Read 0x0000_012F after that fill -> cpu_ready in the 2nd cycle after acceptance, data=0xA000_000F, cpu_hit=1, no L2 activity.
- Write 0xDEAD_BEEF to 0x123 (hit), then read 0x0000_0223 (same index 2, tag 2) -> l2_write with l2_addr=0x120 and word 3=0xDEAD_BEEF, then l2_read with l2_addr=0x220, then the read data returns.
- Write miss 0x0000_0345 data 0x1234_5678 -> fill from 0x340, then a read of 0x345 hits with 0x1234_5678; a write-back of that line later carries it.
- Assert rst_n low while ALLOCATE waits on l2_ready -> next edge l2_read=0 and all outputs 0; re-read 0x123 misses.
- Pulse l2_ready in IDLE, and cpu_read+cpu_write together -> stray ready ignored; the dual request completes as a write (cpu_data_out=0, line dirty).
